// File: rtl/actor_port_pkg.sv
// Shared definitions for the actor dataflow port protocol: COUNT field sizing,
// the single legal token count, and pointer-width sizing for token queues.
package actor_port_pkg;

  localparam int COUNT_W_DEF = 16;
  localparam int COUNT_ONE   = 1;

  // Address width needed to index a queue of the given depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/actor_token_queue_mem.sv
// Token storage for actor_token_queue: DEPTH x WIDTH register array with one
// synchronous write port and one asynchronous read port.
module actor_token_queue_mem
  import actor_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_we,
  input  logic [ptr_width(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic [ptr_width(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]            o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; stale entries are never visible because the
  // queue masks its read data with the occupancy-derived valid.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/actor_token_queue.sv
// Single-clock first-word-fall-through token FIFO joining an actor output port
// (write side) to an actor input port (read side), with sticky error flags.
module actor_token_queue
  import actor_port_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   In_DATA,
  input  logic               In_SEND,
  input  logic [COUNT_W-1:0] In_COUNT,
  output logic               In_RDY,
  output logic               In_ACK,
  output logic [WIDTH-1:0]   Out_DATA,
  output logic               Out_SEND,
  output logic [COUNT_W-1:0] Out_COUNT,
  input  logic               Out_ACK,
  output logic               Err_OVF,
  output logic               Err_CNT
);

  localparam int                 PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_INC  = PTR_W'(1);
  localparam logic [PTR_W:0]     CNT_INC  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [COUNT_W-1:0] TOK_ONE  = COUNT_W'(COUNT_ONE);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_in_ack;
  logic             r_err_ovf;
  logic             r_err_cnt;

  logic             w_full;
  logic             w_in_rdy;
  logic             w_out_send;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;

  assign w_full     = (r_count == CNT_FULL);
  // Gated by RESET so the producer sees no space while the queue is held clear.
  assign w_in_rdy   = RESET & ~w_full;
  assign w_out_send = (r_count != '0);
  assign w_push     = In_SEND & w_in_rdy;
  assign w_pop      = Out_ACK & w_out_send;

  actor_token_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (In_DATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_in_ack  <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_cnt <= 1'b0;
    end else begin
      r_in_ack <= w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_INC;
        2'b01:   r_count <= r_count - CNT_INC;
        default: r_count <= r_count;
      endcase
      if (In_SEND && w_full)               r_err_ovf <= 1'b1;
      if (w_push && (In_COUNT != TOK_ONE)) r_err_cnt <= 1'b1;
    end
  end

  assign In_RDY    = w_in_rdy;
  assign In_ACK    = r_in_ack;
  assign Out_SEND  = w_out_send;
  assign Out_DATA  = w_out_send ? w_rd_data : '0;
  assign Out_COUNT = COUNT_W'(r_count);
  assign Err_OVF   = r_err_ovf;
  assign Err_CNT   = r_err_cnt;

endmodule

// File: tb/tb_actor_token_queue.sv
// Self-checking bench for actor_token_queue: a table of per-cycle vectors with
// hand-computed expected outputs, plus a hand-written mid-stream reset sequence.
module tb_actor_token_queue;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic [WIDTH-1:0]   in_data;
  logic               in_send;
  logic [COUNT_W-1:0] in_count;
  logic               in_rdy;
  logic               in_ack;
  logic [WIDTH-1:0]   out_data;
  logic               out_send;
  logic [COUNT_W-1:0] out_count;
  logic               out_ack;
  logic               err_ovf;
  logic               err_cnt;

  int n_total = 0;
  int n_pass  = 0;

  actor_token_queue #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .In_DATA   (in_data),
    .In_SEND   (in_send),
    .In_COUNT  (in_count),
    .In_RDY    (in_rdy),
    .In_ACK    (in_ack),
    .Out_DATA  (out_data),
    .Out_SEND  (out_send),
    .Out_COUNT (out_count),
    .Out_ACK   (out_ack),
    .Err_OVF   (err_ovf),
    .Err_CNT   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         send;
    logic [7:0]   data;
    logic [15:0]  cnt;
    logic         ack;
    logic         e_rdy;
    logic         e_inack;
    logic         e_osend;
    logic [7:0]   e_odata;
    logic [15:0]  e_ocount;
    logic         e_ovf;
    logic         e_ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic send, input logic [7:0] data, input logic [15:0] cnt,
                              input logic ack, input logic e_rdy, input logic e_inack,
                              input logic e_osend, input logic [7:0] e_odata,
                              input logic [15:0] e_ocount, input logic e_ovf, input logic e_ecnt);
    vec_t v;
    v.send = send; v.data = data; v.cnt = cnt; v.ack = ack;
    v.e_rdy = e_rdy; v.e_inack = e_inack; v.e_osend = e_osend; v.e_odata = e_odata;
    v.e_ocount = e_ocount; v.e_ovf = e_ovf; v.e_ecnt = e_ecnt;
    return v;
  endfunction

  task automatic check_all(input string tag, input logic e_rdy, input logic e_inack,
                           input logic e_osend, input logic [7:0] e_odata,
                           input logic [15:0] e_ocount, input logic e_ovf, input logic e_ecnt);
    check({tag, " In_RDY"},    32'(in_rdy),    32'(e_rdy));
    check({tag, " In_ACK"},    32'(in_ack),    32'(e_inack));
    check({tag, " Out_SEND"},  32'(out_send),  32'(e_osend));
    check({tag, " Out_DATA"},  32'(out_data),  32'(e_odata));
    check({tag, " Out_COUNT"}, 32'(out_count), 32'(e_ocount));
    check({tag, " Err_OVF"},   32'(err_ovf),   32'(e_ovf));
    check({tag, " Err_CNT"},   32'(err_cnt),   32'(e_ecnt));
  endtask

  initial begin
    // Expected values are the outputs observed one cycle after the vector's edge.
    //           send data   cnt ack  rdy iack osnd odata cnt ovf ecnt
    vecs.push_back(mk(1, 8'h5A, 1, 0,  1, 1, 1, 8'h5A, 1, 0, 0)); // single token
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 0, 0)); // pop it
    vecs.push_back(mk(1, 8'h01, 1, 0,  1, 1, 1, 8'h01, 1, 0, 0)); // fill
    vecs.push_back(mk(1, 8'h02, 1, 0,  1, 1, 1, 8'h01, 2, 0, 0));
    vecs.push_back(mk(1, 8'h03, 1, 0,  1, 1, 1, 8'h01, 3, 0, 0));
    vecs.push_back(mk(1, 8'h04, 1, 0,  0, 1, 1, 8'h01, 4, 0, 0));
    vecs.push_back(mk(1, 8'h05, 1, 0,  0, 0, 1, 8'h01, 4, 1, 0)); // overflow dropped
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 1, 8'h02, 3, 1, 0)); // drain
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 1, 8'h03, 2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 1, 8'h04, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 8'h0F, 1, 0,  1, 1, 1, 8'h0F, 1, 1, 0)); // occupancy 1
    for (int k = 0; k < 10; k++) begin                             // push+pop, wraps
      vecs.push_back(mk(1, 8'(8'h10 + k), 1, 1, 1, 1, 1, 8'(8'h10 + k), 1, 1, 0));
    end
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 1, 0)); // drain last
    vecs.push_back(mk(1, 8'hA5, 1, 1,  1, 1, 1, 8'hA5, 1, 1, 0)); // pop ignored on empty
    vecs.push_back(mk(0, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 8'h33, 3, 0,  1, 1, 1, 8'h33, 1, 1, 1)); // bad count
    vecs.push_back(mk(1, 8'h44, 1, 0,  1, 1, 1, 8'h33, 2, 1, 1));
    vecs.push_back(mk(1, 8'h55, 1, 0,  1, 1, 1, 8'h33, 3, 1, 1));

    rst_n = 1'b0; in_send = 1'b0; in_data = '0; in_count = 16'd1; out_ack = 1'b0;
    #3;
    check_all("reset", 0, 0, 0, 8'h00, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release In_RDY", 32'(in_rdy), 32'd1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      in_send  = vecs[i].send;
      in_data  = vecs[i].data;
      in_count = vecs[i].cnt;
      out_ack  = vecs[i].ack;
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_inack, vecs[i].e_osend,
                vecs[i].e_odata, vecs[i].e_ocount, vecs[i].e_ovf, vecs[i].e_ecnt);
    end

    // Mid-stream reset with three tokens queued and both flags set.
    in_send = 1'b0; out_ack = 1'b0; in_count = 16'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst", 0, 0, 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check_all("midrst hold", 0, 0, 0, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check_all("midrst release", 1, 0, 0, 8'h00, 0, 0, 0);

    // Queue is usable again after reset; old tokens are gone.
    @(negedge clk);
    in_send = 1'b1; in_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    in_send = 1'b0;
    check_all("post rst push", 1, 1, 1, 8'h77, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/actor_token_queue.md
# actor_token_queue

Single-clock token FIFO that links two generated actors over the dataflow port protocol. Its write side is the receiving end of an actor output port (`*_DATA`, `*_SEND`, `*_COUNT`, `*_RDY`, `*_ACK`). Its read side is the transmitting end for an actor input port (`*_DATA`, `*_SEND`, `*_COUNT`, `*_ACK`). It buffers up to DEPTH tokens, so a producer firing is not blocked by a consumer that is not yet ready.

## Interface
- WIDTH, 8, token data width in bits
- DEPTH, 4, token capacity; power of two, minimum 2
- COUNT_W, 16, width of the COUNT fields

- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- In_DATA  in  WIDTH  token from the producer's Output_DATA
- In_SEND  in  1  producer write strobe, one token per cycle high
- In_COUNT  in  COUNT_W  producer token count; only 1 is legal
- In_RDY  out  1  space available; drives the producer's Output_RDY
- In_ACK  out  1  write-accepted pulse; drives the producer's Output_ACK
- Out_DATA  out  WIDTH  head token; drives the consumer's InputN_DATA
- Out_SEND  out  1  queue non-empty; drives the consumer's InputN_SEND
- Out_COUNT  out  COUNT_W  current occupancy, zero-extended
- Out_ACK  in  1  consumer pop strobe, from the consumer's InputN_ACK
- Err_OVF  out  1  sticky flag: write attempted while full
- Err_CNT  out  1  sticky flag: In_COUNT != 1 on an accepted write

## Operation
- State: write pointer, read pointer (log2(DEPTH) bits each, wrapping naturally), occupancy counter (log2(DEPTH)+1 bits), the two sticky flags, and the In_ACK register.
- Accept condition: push = In_SEND & In_RDY.
  - On push, the token is written at the write pointer and the pointer increments, wrapping from DEPTH-1 to 0.
- Pop condition: pop = Out_ACK & Out_SEND.
  - On pop, the read pointer increments with the same wrap.
  - Out_ACK while empty is ignored; no state changes.
- Occupancy update: +1 on push only, -1 on pop only, unchanged on both or neither.
- In_RDY = (occupancy != DEPTH), combinational from registers.
- Simultaneous push and pop while full cannot occur, because In_RDY is low.
- Simultaneous push and pop while empty: push is taken; pop is ignored because Out_SEND is low.
- In_SEND while full: the token is dropped, pointers and count are unchanged, In_ACK stays low, and Err_OVF is set.
- In_COUNT other than 1 on a push: exactly one token (In_DATA) is stored, and Err_CNT is set.
- Out_SEND = (occupancy != 0).
- Out_DATA = the entry at the read pointer when Out_SEND is high, otherwise all zeros.
- Out_COUNT = occupancy, zero-extended to COUNT_W.
- Err_OVF and Err_CNT clear only on reset.

## Timing
- Reset (RESET low), asynchronous:
  - Pointers, count, Err_OVF, Err_CNT and In_ACK are cleared.
  - Outputs while asserted: In_RDY = 0, In_ACK = 0, Out_SEND = 0, Out_DATA = 0, Out_COUNT = 0, both error flags 0.
  - In_RDY is forced low during reset and rises in the same cycle RESET deasserts.
  - Token storage is not reset; its contents are masked by Out_SEND.
- Reset mid-operation discards all buffered tokens immediately.
- Write-to-read latency: a token pushed at edge N appears on Out_SEND and Out_DATA in cycle N+1 (registered, first-word fall-through).
- In_ACK is high in the cycle after the accepting edge, for exactly one cycle per token.
  - Back-to-back pushes give a continuous In_ACK.
- Throughput: one push and one pop per cycle, sustained.
- Pop at edge N: the next head, or Out_SEND = 0, is visible in cycle N+1.
- In_RDY reflects registered occupancy only; freeing a slot with a pop at edge N raises In_RDY in cycle N+1.

## Structure
- Shared package `actor_port_pkg`:
  - COUNT_W default (16)
  - legal token count constant (COUNT_ONE = 1)
  - helper function for pointer width, clog2
- Sub-module `actor_token_queue_mem`:
  - DEPTH x WIDTH register array
  - one synchronous write port, one asynchronous read port
  - no reset
- Top module holds pointers, occupancy, handshake logic and flags.

## Test plan
- Reset then single token: release RESET, then In_SEND with In_DATA = 0x5A, In_COUNT = 1 for one cycle.
  - Next cycle: Out_SEND = 1, Out_DATA = 0x5A, Out_COUNT = 1, In_ACK = 1.
  - Out_ACK for one cycle, then Out_SEND = 0 and Out_DATA = 0.
- Fill and overflow (DEPTH = 4): push 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - In_RDY = 0 and Out_COUNT = 4.
  - A fifth In_SEND with 0x05 sets Err_OVF, gives no In_ACK, and the count stays 4.
  - Four pops return 0x01..0x04 in order.
- Wrap-around: 10 cycles of simultaneous push (0x10..0x19) and pop, starting from occupancy 1.
  - Count holds at 1 throughout; pops return tokens in push order with no loss.
- Empty edge case: Out_ACK high with the queue empty while In_SEND pushes 0xA5.
  - 0xA5 is retained; Out_COUNT = 1 next cycle.
- Bad count: push with In_COUNT = 3 and In_DATA = 0x33.
  - Err_CNT = 1, Out_COUNT = 1, Out_DATA = 0x33.
- Reset mid-stream: with 3 tokens queued, pulse RESET low between clock edges.
  - Out_SEND, Out_COUNT, In_ACK and the error flags go to 0 immediately.
  - In_RDY = 0 during reset and 1 once RESET is released.
